mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory-access stage of the LC-3 pipeline, between Execute and Writeback. Runs the
//  data-memory transaction for LD/LDR/LDI/ST/STR/STI: one access for direct ops, two for
//  indirect ops (pointer read, then data access). Drives memout to Writeback (W_Control=1).
//  Completion is signalled by a done pulse; a wait-state timeout reports err.
// PARAMETERS
//  WAIT_LIMIT  15  max wait cycles per access (Data_ready low) before abort; >=1
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   asynchronous, active-low reset (0 = reset)
//  enable_memaccess in   1   start strobe from controller; sampled only in IDLE
//  M_Control        in   2   0=load direct, 1=load indirect, 2=store direct, 3=store indirect
//  M_addr           in   16  effective address from Execute (pcout/aluout)
//  M_data           in   16  store data (SR contents)
//  Data_dout        in   16  read data from data memory
//  Data_ready       in   1   memory completes current access this cycle
//  Data_addr        out  16  memory address
//  Data_din         out  16  memory write data
//  Data_en          out  1   access request
//  Data_rd          out  1   1=read, 0=write
//  memout           out  16  last loaded word, to Writeback
//  busy             out  1   transaction in progress (state != IDLE)
//  done             out  1   one-cycle completion pulse
//  err              out  1   one-cycle timeout pulse, coincident with done
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; addr_reg, data_reg, memout, wait_cnt = 0;
//   done=err=0; Data_en=0 immediately, without waiting for a clock edge.
//   Deasserting reset mid-transaction abandons it; no done is produced.
//  States: IDLE, IND, ACCESS. All memory-side outputs decode from registers only;
//   there is no combinational input-to-output path.
//  IDLE: Data_en=0, busy=0. If enable_memaccess=1: latch M_addr->addr_reg,
//   M_data->data_reg, M_Control->ctl_reg, clear wait_cnt. Next state is IND if
//   M_Control[0]=1, else ACCESS.
//  IND: Data_en=1, Data_rd=1, Data_addr=addr_reg. If Data_ready=1: addr_reg<=Data_dout,
//   wait_cnt<=0, next state ACCESS.
//  ACCESS: Data_en=1, Data_addr=addr_reg, Data_din=data_reg, Data_rd=~ctl_reg[1].
//   If Data_ready=1: on a load, memout<=Data_dout; done<=1 next cycle; next state IDLE.
//  Wait counting: in IND or ACCESS with Data_ready=0, wait_cnt increments. If
//   Data_ready=0 while wait_cnt==WAIT_LIMIT: abort to IDLE, done=err=1 next cycle,
//   memout unchanged. Data_ready=1 on that same cycle takes priority over the abort.
//  Outside ACCESS: Data_rd=1 and Data_din=data_reg.
//  Latency with zero wait states, edge 0 = edge that samples enable:
//   direct: done high in cycle 2; indirect: done high in cycle 3. memout is valid
//   when done is high and holds until the next successful load.
//  enable_memaccess while busy=1 is ignored (no queueing). enable in the same cycle
//   that done is high is accepted (state is IDLE then).
//  Indirect pointer is used as the full 16 bits. No address wrap logic is needed;
//   0xFFFF is a legal address.
//  Stores never modify memout. err is only asserted together with done.
// TESTING
//  1 LD: M_Control=0, M_addr=0x3005, mem[0x3005]=0xBEEF, Data_ready=1 ->
//    Data_en/Data_rd=1 @0x3005 one cycle; done in cycle 2; memout=0xBEEF.
//  2 LDI: M_Control=1, M_addr=0x3010, mem[0x3010]=0x4000, mem[0x4000]=0x8001 ->
//    reads 0x3010 then 0x4000; done in cycle 3; memout=0x8001.
//  3 STI, 2 wait states per access: M_Control=3, M_addr=0x3020, mem[0x3020]=0x5000,
//    M_data=0x1234 -> write to 0x5000 with data 0x1234 and Data_rd=0; done in cycle 7;
//    memout unchanged.
//  4 Timeout: WAIT_LIMIT=3, Data_ready tied 0 -> Data_en high 4 cycles, then done=err=1
//    for 1 cycle; busy=0.
//  5 reset=0 pulsed mid-ACCESS of a LD -> Data_en=0 same cycle, memout=0, no done;
//    a new LD after release completes normally.
//  6 enable_memaccess held high during an LDI -> exactly one transaction until done;
//    the next one starts in the done cycle.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage of the LC-3 pipeline, between Execute and Writeback.
// Runs one data-memory access for LD/ST/LDR/STR, or two for LDI/STI
// (a pointer read followed by the data access). Each access may stall on
// Data_ready for up to WAIT_LIMIT+1 cycles before the transaction is abandoned
// with an err pulse. All memory-side outputs decode from registers only.
module mem_access #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_memaccess,
  input  logic [1:0]  M_Control,
  input  logic [15:0] M_addr,
  input  logic [15:0] M_data,
  input  logic [15:0] Data_dout,
  input  logic        Data_ready,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  output logic        Data_en,
  output logic        Data_rd,
  output logic [15:0] memout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IND    = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              is_store;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_expired;

  // Stall budget for the current access is used up when the counter reaches the limit.
  assign wait_expired = (wait_cnt == CNT_LIMIT);

  // Memory-side outputs are pure decodes of the state and latched operands.
  assign Data_en   = (state != IDLE);
  assign busy      = (state != IDLE);
  assign Data_addr = addr_reg;
  assign Data_din  = data_reg;
  assign Data_rd   = (state == ACCESS) ? ~is_store : 1'b1;

  // Transaction sequencer: latch the request, optionally chase the pointer, then access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr_reg <= '0;
      data_reg <= '0;
      is_store <= 1'b0;
      wait_cnt <= '0;
      memout   <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_memaccess) begin
            addr_reg <= M_addr;
            data_reg <= M_data;
            is_store <= M_Control[1];
            wait_cnt <= '0;
            state    <= M_Control[0] ? IND : ACCESS;
          end
        end
        IND: begin
          if (Data_ready) begin
            addr_reg <= Data_dout;
            wait_cnt <= '0;
            state    <= ACCESS;
          end else if (wait_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          if (Data_ready) begin
            if (!is_store) begin
              memout <= Data_dout;
            end
            done  <= 1'b1;
            state <= IDLE;
          end else if (wait_expired) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a transaction-level model predicts each
// completion, a memory responder with programmable wait states services the
// bus, and a monitor compares every done pulse against the expected queue.
module tb_mem_access;

  localparam int LIM = 3;

  typedef struct {
    logic [15:0] memout;
    logic        err;
    int          lat;
    int          wr;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    int          issue;
    int          wr_base;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        enable_memaccess;
  logic [1:0]  M_Control;
  logic [15:0] M_addr;
  logic [15:0] M_data;
  logic [15:0] Data_dout;
  logic        Data_ready;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        Data_en;
  logic        Data_rd;
  logic [15:0] memout;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] ref_memout;
  exp_t        sb[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int w_first  = 0;
  int w_second = 0;
  int wr_cnt   = 0;
  int last_run = 0;

  mem_access #(.WAIT_LIMIT(LIM)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_memaccess (enable_memaccess),
    .M_Control        (M_Control),
    .M_addr           (M_addr),
    .M_data           (M_data),
    .Data_dout        (Data_dout),
    .Data_ready       (Data_ready),
    .Data_addr        (Data_addr),
    .Data_din         (Data_din),
    .Data_en          (Data_en),
    .Data_rd          (Data_rd),
    .memout           (memout),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Transaction-level prediction: pointer chase, stall budget, load/store effect.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                                 input int w1, input int w2);
    exp_t e;
    int wd;
    logic [15:0] ptr;
    e = '{memout: 16'h0, err: 1'b0, lat: 0, wr: 0, wr_addr: 16'h0, wr_data: 16'h0, issue: 0, wr_base: 0};
    ptr = a;
    wd  = w1;
    if (op[0]) begin
      if (w1 > LIM) begin
        e.err = 1'b1;
        e.lat = LIM + 1;
      end else begin
        e.lat = w1 + 1;
        ptr   = ref_mem[a];
        wd    = w2;
      end
    end
    if (!e.err) begin
      if (wd > LIM) begin
        e.err = 1'b1;
        e.lat += LIM + 1;
      end else begin
        e.lat += wd + 1;
        if (op[1]) begin
          ref_mem[ptr] = d;
          e.wr      = 1;
          e.wr_addr = ptr;
          e.wr_data = d;
        end else begin
          ref_memout = ref_mem[ptr];
        end
      end
    end
    e.memout = ref_memout;
    return e;
  endfunction

  // Memory responder: k-th access of a transaction stalls for w_first/w_second cycles.
  initial begin : responder
    int idx;
    int wcnt;
    int run_len;
    int w;
    idx = 0; wcnt = 0; run_len = 0;
    Data_ready = 1'b0;
    Data_dout  = 16'h0;
    forever begin
      @(posedge clock);
      #1;
      Data_ready = 1'b0;
      Data_dout  = 16'($urandom);
      if (!reset || !Data_en) begin
        if (run_len != 0) last_run = run_len;
        idx = 0; wcnt = 0; run_len = 0;
      end else begin
        run_len++;
        w = (idx == 0) ? w_first : w_second;
        if (wcnt >= w) begin
          Data_ready = 1'b1;
          wcnt = 0;
          idx++;
          if (Data_rd) Data_dout = mem[Data_addr];
          else begin
            mem[Data_addr] = Data_din;
            wr_cnt++;
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: every done pulse retires the oldest expected transaction.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (reset && done) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected no transaction (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("memout", 32'(memout), 32'(e.memout));
          chk("err", 32'(err), 32'(e.err));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
          chk("en_cycles", 32'(last_run), 32'(e.lat));
          chk("write_count", 32'(wr_cnt - e.wr_base), 32'(e.wr));
          if (e.wr != 0) chk("write_data", 32'(mem[e.wr_addr]), 32'(e.wr_data));
        end
      end else if (reset && err) begin
        n_checks++;
        $display("FAIL err_without_done: got err=1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock);
      #3;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL completion_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                       input int w1, input int w2);
    exp_t e;
    @(negedge clock);
    w_first  = w1;
    w_second = w2;
    M_Control = op;
    M_addr    = a;
    M_data    = d;
    enable_memaccess = 1'b1;
    e = model(op, a, d, w1, w2);
    e.issue   = cyc + 1;
    e.wr_base = wr_cnt;
    sb.push_back(e);
  endtask

  task automatic run_tx(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        input int w1, input int w2);
    issue(op, a, d, w1, w2);
    @(negedge clock);
    enable_memaccess = 1'b0;
    M_addr = 16'($urandom);
    M_data = 16'($urandom);
    M_Control = 2'($urandom);
    wait_idle(200);
  endtask

  task automatic set_word(input logic [15:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    int w1;
    int w2;
    int n;
    reset = 1'b0;
    enable_memaccess = 1'b0;
    M_Control = 2'd0;
    M_addr = 16'h0;
    M_data = 16'h0;
    ref_memout = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    chk("reset_data_en", 32'(Data_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_memout", 32'(memout), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed: LD, LDI, STI with stalls, timeout, boundary stalls
    set_word(16'h3005, 16'hBEEF);
    run_tx(2'd0, 16'h3005, 16'h0000, 0, 0);
    set_word(16'h3010, 16'h4000);
    set_word(16'h4000, 16'h8001);
    run_tx(2'd1, 16'h3010, 16'h0000, 0, 0);
    set_word(16'h3020, 16'h5000);
    run_tx(2'd3, 16'h3020, 16'h1234, 2, 2);
    chk("sti_target", 32'(mem[16'h5000]), 32'h1234);
    run_tx(2'd0, 16'h3005, 16'h0000, 1000, 1000);
    run_tx(2'd1, 16'h3010, 16'h0000, LIM, LIM);
    run_tx(2'd1, 16'h3010, 16'h0000, LIM, LIM + 1);
    set_word(16'hFFFF, 16'hFFFF);
    run_tx(2'd2, 16'hFFFF, 16'hA5A5, 0, 0);
    run_tx(2'd1, 16'hFFFF, 16'h0000, 0, 0);

    // Reset pulsed mid-access abandons the transaction
    issue(2'd0, 16'h3005, 16'h0000, 3, 0);
    @(negedge clock);
    enable_memaccess = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midreset_data_en", 32'(Data_en), 32'd0);
    chk("midreset_memout", 32'(memout), 32'd0);
    sb.delete();
    ref_memout = 16'h0;
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    run_tx(2'd0, 16'h3005, 16'h0000, 0, 0);

    // Enable held through an LDI: one transaction, next accepted in the done cycle
    issue(2'd1, 16'h3010, 16'h0000, 1, 0);
    n = 0;
    while (n < 50) begin
      @(posedge clock);
      #3;
      n++;
      if (done) break;
    end
    chk("held_first_done", 32'(done), 32'd1);
    e = model(2'd1, 16'h3010, 16'h0000, 1, 0);
    e.issue   = cyc + 1;
    e.wr_base = wr_cnt;
    sb.push_back(e);
    @(posedge clock);
    #3;
    enable_memaccess = 1'b0;
    chk("held_second_start", 32'(busy), 32'd1);
    wait_idle(200);

    // Randomized mix of all four operations with random stalls
    for (int t = 0; t < 60; t++) begin
      w1 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(LIM + 1, LIM + 3)) : int'($urandom_range(0, LIM));
      w2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(LIM + 1, LIM + 3)) : int'($urandom_range(0, LIM));
      run_tx(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), w1, w2);
    end

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
